// File: rtl/wb_sched.sv
// wb_sched: shares one register-file write port between single-cycle EX results and buffered LSU results,
// tracks pending long-latency destinations, and forces a write-back slot when the LSU path starves.
module wb_sched #(
  parameter int STARVE_LIM = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        ex_wb_en_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [31:0] ex_rd_data_i,
  input  logic        lsu_issue_i,
  input  logic [4:0]  lsu_issue_rd_i,
  output logic        issue_stall_o,
  input  logic        lsu_wb_valid_i,
  input  logic [4:0]  lsu_wb_rd_i,
  input  logic [31:0] lsu_wb_data_i,
  output logic        lsu_wb_ready_o,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  output logic        id_stall_o,
  output logic        regs_wb_en_o,
  output logic [4:0]  regs_rd_addr_o,
  output logic [31:0] regs_rd_data_o,
  output logic        ex_hold_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIM + 1);
  typedef enum logic {NORMAL, HOLD} state_t;
  state_t state;
  logic [31:0] pend;
  logic [4:0] q_rd [FIFO_DEPTH];
  logic [31:0] q_data [FIFO_DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] cnt;
  logic [CW-1:0] blk_cnt;
  logic ex_own, empty, full, deq, bypass, enq, accept, lsu_wr;
  logic [4:0] lsu_rd;
  logic [31:0] lsu_data;
  always_comb begin
    ex_own = ex_wb_en_i && ex_rd_addr_i != '0;
    empty = cnt == '0;
    full = cnt == (AW+1)'(FIFO_DEPTH);
    deq = rest && !empty && !ex_own;
    bypass = rest && empty && !ex_own && lsu_wb_valid_i;
    enq = rest && lsu_wb_valid_i && !bypass && !full;
    lsu_wr = deq || bypass;
    lsu_rd = deq ? q_rd[rptr] : lsu_wb_rd_i;
    lsu_data = deq ? q_data[rptr] : lsu_wb_data_i;
    issue_stall_o = rest && lsu_issue_i && lsu_issue_rd_i != '0 && pend[lsu_issue_rd_i];
    accept = rest && lsu_issue_i && !issue_stall_o;
    id_stall_o = rest && ((id_rs1_addr_i != '0 && pend[id_rs1_addr_i]) ||
                          (id_rs2_addr_i != '0 && pend[id_rs2_addr_i]));
    lsu_wb_ready_o = bypass || (rest && !full);
    regs_wb_en_o = rest && (ex_own || (lsu_wr && lsu_rd != '0));
    regs_rd_addr_o = !regs_wb_en_o ? '0 : ex_own ? ex_rd_addr_i : lsu_rd;
    regs_rd_data_o = !regs_wb_en_o ? '0 : ex_own ? ex_rd_data_i : lsu_data;
  end
  always_ff @(posedge clk)
    if (enq) begin
      q_rd[wptr] <= lsu_wb_rd_i;
      q_data[wptr] <= lsu_wb_data_i;
    end
  always_ff @(posedge clk) begin
    if (!rest) begin
      pend <= '0;
      rptr <= '0;
      wptr <= '0;
      cnt <= '0;
      blk_cnt <= '0;
      state <= NORMAL;
      ex_hold_o <= 1'b0;
    end else begin
      if (lsu_wr) pend[lsu_rd] <= 1'b0;
      if (accept && lsu_issue_rd_i != '0) pend[lsu_issue_rd_i] <= 1'b1;
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(enq) - (AW+1)'(deq);
      if (state == HOLD) begin
        state <= NORMAL;
        ex_hold_o <= 1'b0;
        blk_cnt <= '0;
      end else if (deq) begin
        blk_cnt <= '0;
      end else if (!empty && ex_own) begin
        if (blk_cnt == CW'(STARVE_LIM - 1)) begin
          state <= HOLD;
          ex_hold_o <= 1'b1;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: vector table, directed corner sequences and random traffic checked against a queue-based model.
module tb_wb_sched;
  localparam int LIM = 4;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rest, ex_wb_en_i, lsu_issue_i, lsu_wb_valid_i;
  logic [4:0] ex_rd_addr_i, lsu_issue_rd_i, lsu_wb_rd_i, id_rs1_addr_i, id_rs2_addr_i, regs_rd_addr_o;
  logic [31:0] ex_rd_data_i, lsu_wb_data_i, regs_rd_data_o;
  logic issue_stall_o, lsu_wb_ready_o, id_stall_o, regs_wb_en_o, ex_hold_o;
  wb_sched #(.STARVE_LIM(LIM), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rest(rest), .ex_wb_en_i(ex_wb_en_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i),
    .lsu_issue_i(lsu_issue_i), .lsu_issue_rd_i(lsu_issue_rd_i), .issue_stall_o(issue_stall_o),
    .lsu_wb_valid_i(lsu_wb_valid_i), .lsu_wb_rd_i(lsu_wb_rd_i), .lsu_wb_data_i(lsu_wb_data_i),
    .lsu_wb_ready_o(lsu_wb_ready_o), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_stall_o(id_stall_o), .regs_wb_en_o(regs_wb_en_o), .regs_rd_addr_o(regs_rd_addr_o),
    .regs_rd_data_o(regs_rd_data_o), .ex_hold_o(ex_hold_o)
  );
  typedef struct packed {
    logic rst_n; logic ex_en; logic [4:0] ex_rd; logic [31:0] ex_d;
    logic iss; logic [4:0] ird; logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic [4:0] rs1; logic [4:0] rs2;
    logic e_wb; logic [4:0] e_addr; logic [31:0] e_data; logic e_rdy; logic e_ist; logic e_id;
  } vec_t;
  typedef struct packed {logic [4:0] rd; logic [31:0] d;} ent_t;
  ent_t q[$];
  bit [31:0] m_pend;
  int streak;
  bit m_hold;
  int tests = 0, fails = 0;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask
  function automatic vec_t idle();
    vec_t v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction
  function automatic vec_t tv(logic r, logic ee, logic [4:0] er, logic [31:0] ed, logic is, logic [4:0] ir,
                              logic lv, logic [4:0] lr, logic [31:0] ld, logic [4:0] s1, logic [4:0] s2,
                              logic wb, logic [4:0] wa, logic [31:0] wd, logic rdy, logic ist, logic idst);
    vec_t v;
    v.rst_n = r; v.ex_en = ee; v.ex_rd = er; v.ex_d = ed; v.iss = is; v.ird = ir;
    v.lv = lv; v.lrd = lr; v.ld = ld; v.rs1 = s1; v.rs2 = s2;
    v.e_wb = wb; v.e_addr = wa; v.e_data = wd; v.e_rdy = rdy; v.e_ist = ist; v.e_id = idst;
    return v;
  endfunction
  // Drive one cycle, compare the DUT against the model, then advance the model past the clock edge.
  task automatic tick(input vec_t v);
    bit own, blocked, head_wr, bypass, full, ist, idst, rdy, we;
    logic [4:0] wa, clr;
    logic [31:0] wd;
    ent_t e;
    @(negedge clk);
    rest = v.rst_n; ex_wb_en_i = v.ex_en; ex_rd_addr_i = v.ex_rd; ex_rd_data_i = v.ex_d;
    lsu_issue_i = v.iss; lsu_issue_rd_i = v.ird; lsu_wb_valid_i = v.lv; lsu_wb_rd_i = v.lrd;
    lsu_wb_data_i = v.ld; id_rs1_addr_i = v.rs1; id_rs2_addr_i = v.rs2;
    #2;
    if (!v.rst_n) begin
      chk("rst_wb_en", regs_wb_en_o, 0);
      chk("rst_ready", lsu_wb_ready_o, 0);
      chk("rst_stalls", {issue_stall_o, id_stall_o}, 0);
      q.delete(); m_pend = 0; streak = 0; m_hold = 0;
      return;
    end
    own = v.ex_en && v.ex_rd != 0;
    ist = v.iss && v.ird != 0 && m_pend[v.ird];
    idst = (v.rs1 != 0 && m_pend[v.rs1]) || (v.rs2 != 0 && m_pend[v.rs2]);
    full = q.size() >= DEPTH;
    blocked = own && q.size() > 0;
    head_wr = 0; bypass = 0; we = 0; wa = 0; wd = 0; clr = 0;
    if (own) begin
      we = 1; wa = v.ex_rd; wd = v.ex_d;
    end else if (q.size() > 0) begin
      e = q.pop_front(); head_wr = 1; clr = e.rd;
      if (e.rd != 0) begin we = 1; wa = e.rd; wd = e.d; end
    end else if (v.lv) begin
      bypass = 1; clr = v.lrd;
      if (v.lrd != 0) begin we = 1; wa = v.lrd; wd = v.ld; end
    end
    rdy = bypass || !full;
    chk("wb_en", regs_wb_en_o, we);
    chk("wb_addr", regs_rd_addr_o, wa);
    chk("wb_data", regs_rd_data_o, wd);
    chk("lsu_ready", lsu_wb_ready_o, rdy);
    chk("issue_stall", issue_stall_o, ist);
    chk("id_stall", id_stall_o, idst);
    chk("ex_hold", ex_hold_o, m_hold);
    if (v.lv && !bypass && !full) q.push_back('{v.lrd, v.ld});
    if (clr != 0) m_pend[clr] = 0;
    if (v.iss && !ist && v.ird != 0) m_pend[v.ird] = 1;
    if (m_hold) begin
      streak = 0; m_hold = 0;
    end else if (head_wr) begin
      streak = 0;
    end else if (blocked) begin
      streak++;
      if (streak >= LIM) m_hold = 1;
    end
  endtask
  initial begin
    vec_t v;
    // reset, then REQ scenarios: RAW on rd5 with bypass, WAW on rd9, EX priority, rd=0 writes, same-cycle clear
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(tv(0, 1, 3, 32'h33, 1, 5, 1, 7, 32'h11, 5, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 1, 5, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 1, 5, 32'hA5, 5, 0, 1, 5, 32'hA5, 1, 0, 1));
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(tv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 1));
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, 1, 3, 32'h33, 0, 0, 1, 7, 32'h11, 0, 0, 1, 3, 32'h33, 1, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h11, 1, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, 1, 0, 32'hFF, 0, 0, 1, 0, 32'h22, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 9, 1, 9, 32'h99, 1, 0, 1));
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 1, 9, 1, 9, 32'h1, 0, 0, 1, 9, 32'h1, 1, 1, 0));
    tbl.push_back(tv(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 1, 9, 32'h2, 0, 0, 1, 9, 32'h2, 1, 0, 0));
    foreach (tbl[i]) begin
      tick(tbl[i]);
      chk($sformatf("tbl%0d_wb", i), {regs_wb_en_o, regs_rd_addr_o, regs_rd_data_o}, {tbl[i].e_wb, tbl[i].e_addr, tbl[i].e_data});
      chk($sformatf("tbl%0d_flags", i), {lsu_wb_ready_o, issue_stall_o, id_stall_o}, {tbl[i].e_rdy, tbl[i].e_ist, tbl[i].e_id});
    end
    tick(idle());
    // starvation: one queued entry, EX busy for LIM cycles, then a forced slot
    v = idle(); v.ex_en = 1; v.ex_rd = 1; v.ex_d = 1; v.lv = 1; v.lrd = 2; v.ld = 32'h22;
    tick(v);
    v.lv = 0;
    for (int i = 0; i < LIM; i++) begin
      tick(v);
      chk("starve_no_hold", ex_hold_o, 0);
    end
    tick(idle());
    chk("starve_hold", ex_hold_o, 1);
    chk("starve_head", {regs_wb_en_o, regs_rd_addr_o, regs_rd_data_o}, {1'b1, 5'd2, 32'h22});
    tick(idle());
    chk("starve_release", ex_hold_o, 0);
    // full FIFO back-pressure and ordering
    v = idle(); v.ex_en = 1; v.ex_rd = 1; v.lv = 1; v.lrd = 10; v.ld = 32'hA;
    tick(v);
    v.lrd = 11; v.ld = 32'hB;
    tick(v);
    v.lrd = 12; v.ld = 32'hC;
    tick(v);
    chk("full_ready", lsu_wb_ready_o, 0);
    tick(v);
    chk("full_ready2", lsu_wb_ready_o, 0);
    v.ex_en = 0;
    tick(v);
    chk("order0", {regs_wb_en_o, regs_rd_addr_o, regs_rd_data_o}, {1'b1, 5'd10, 32'hA});
    chk("order0_ready", lsu_wb_ready_o, 0);
    tick(v);
    chk("order1", {regs_wb_en_o, regs_rd_addr_o, regs_rd_data_o}, {1'b1, 5'd11, 32'hB});
    chk("order1_ready", lsu_wb_ready_o, 1);
    tick(idle());
    chk("order2", {regs_wb_en_o, regs_rd_addr_o, regs_rd_data_o}, {1'b1, 5'd12, 32'hC});
    // reset mid-operation discards queued entries and pending bits
    v = idle(); v.iss = 1; v.ird = 4;
    tick(v);
    v = idle(); v.ex_en = 1; v.ex_rd = 1; v.lv = 1; v.lrd = 13; v.ld = 32'hD;
    tick(v);
    v.lrd = 14; v.ld = 32'hE;
    tick(v);
    v.rst_n = 0;
    tick(v);
    chk("midrst_wb", regs_wb_en_o, 0);
    v = idle(); v.rs1 = 4;
    tick(v);
    chk("post_rst_ready", lsu_wb_ready_o, 1);
    chk("post_rst_pend", id_stall_o, 0);
    chk("post_rst_nowrite", regs_wb_en_o, 0);
    tick(idle());
    chk("post_rst_nowrite2", regs_wb_en_o, 0);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v = idle();
      v.rst_n = ($urandom_range(0, 199) != 0);
      v.ex_en = ($urandom_range(0, 9) < 5); v.ex_rd = 5'($urandom_range(0, 7)); v.ex_d = $urandom;
      v.iss = ($urandom_range(0, 9) < 3); v.ird = 5'($urandom_range(0, 7));
      v.lv = ($urandom_range(0, 9) < 5); v.lrd = 5'($urandom_range(0, 7)); v.ld = $urandom;
      v.rs1 = 5'($urandom_range(0, 7)); v.rs2 = 5'($urandom_range(0, 7));
      tick(v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
